// File: rtl/dram_rd_ctrl.sv
// dram_rd_ctrl: AXI4 read master streaming a contiguous DRAM region to the UART transmit path,
// one burst in flight, throttled by tx_almst_full. Define DRAM_RD_PERF_CNT_EN to add stall_cnt.
module dram_rd_ctrl #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 256,
   parameter int ID_W      = 4,
   parameter int BURST_LEN = 16,
   parameter int CNT_W     = 24
) (
   input  logic              AXI_clk,
   input  logic              i_rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  num_beats,
   input  logic              tx_almst_full,
   output logic [ID_W-1:0]   arid,
   output logic [ADDR_W-1:0] araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic              arvalid,
   input  logic              arready,
   input  logic [ID_W-1:0]   rid,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready,
   output logic              rvalid_tx,
   output logic [DATA_W-1:0] data_out,
   output logic              busy,
   output logic              done,
`ifdef DRAM_RD_PERF_CNT_EN
   output logic [31:0]       stall_cnt,
`endif
   output logic              rd_err
);

   typedef enum logic [1:0] {IDLE = 2'b00, ARQ = 2'b01, RDAT = 2'b10, FIN = 2'b11} state_t;

   localparam logic [7:0] BURST_M1 = 8'(BURST_LEN - 1);

   state_t              state_r, state_s;
   logic [ADDR_W-1:0]   addr_r;
   logic [CNT_W-1:0]    remaining_r;
   logic [7:0]          burst_cnt_r;
   logic [7:0]          len_m1_s;
   logic [ADDR_W-1:0]   step_s;
   logic                accept_s, beat_s, last_beat_s;
   logic                rid_unused_s;

   assign arid         = {ID_W{1'b0}};
   assign rid_unused_s = ^rid;
   assign step_s       = ADDR_W'({({1'b0, arlen} + 9'd1), 5'b00000});

   always_ff @(posedge AXI_clk or posedge i_rst) begin
      if (i_rst) state_r <= IDLE;
      else       state_r <= state_s;
   end

   // busy is still high during the done cycle, so a start there is ignored
   always_comb begin
      state_s     = state_r;
      accept_s    = 1'b0;
      beat_s      = 1'b0;
      last_beat_s = 1'b0;
      if (remaining_r >= CNT_W'(BURST_LEN)) len_m1_s = BURST_M1;
      else                                   len_m1_s = remaining_r[7:0] - 8'd1;
      case (state_r)
         IDLE: begin
            if (start && !busy) begin
               accept_s = 1'b1;
               state_s  = (num_beats == {CNT_W{1'b0}}) ? FIN : ARQ;
            end else begin
               state_s = IDLE;
            end
         end
         ARQ: begin
            if (arvalid && arready) state_s = RDAT;
            else                    state_s = ARQ;
         end
         RDAT: begin
            if (rvalid && rready) begin
               beat_s = 1'b1;
               if (burst_cnt_r == 8'd1) begin
                  last_beat_s = 1'b1;
                  state_s     = (remaining_r == CNT_W'(1)) ? FIN : ARQ;
               end else begin
                  state_s = RDAT;
               end
            end else begin
               state_s = RDAT;
            end
         end
         FIN:     state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // rready follows the flag with one cycle of lag and is only offered while in RDAT
   always_ff @(posedge AXI_clk or posedge i_rst) begin
      if (i_rst) begin
         addr_r      <= {ADDR_W{1'b0}};
         remaining_r <= {CNT_W{1'b0}};
         burst_cnt_r <= 8'd0;
         araddr      <= {ADDR_W{1'b0}};
         arlen       <= 8'd0;
         arsize      <= 3'b000;
         arburst     <= 2'b00;
         arvalid     <= 1'b0;
         rready      <= 1'b0;
         rvalid_tx   <= 1'b0;
         data_out    <= {DATA_W{1'b0}};
         busy        <= 1'b0;
         done        <= 1'b0;
         rd_err      <= 1'b0;
      end else begin
         rvalid_tx <= 1'b0;
         done      <= 1'b0;
         rready    <= (state_s == RDAT) && !tx_almst_full;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  addr_r      <= base_addr;
                  remaining_r <= num_beats;
                  rd_err      <= 1'b0;
                  busy        <= 1'b1;
               end else begin
                  busy <= 1'b0;
               end
            end
            ARQ: begin
               if (!arvalid && !tx_almst_full) begin
                  arvalid <= 1'b1;
                  araddr  <= addr_r;
                  arlen   <= len_m1_s;
                  arsize  <= 3'b101;
                  arburst <= 2'b01;
               end else if (arvalid && arready) begin
                  arvalid     <= 1'b0;
                  burst_cnt_r <= arlen + 8'd1;
               end else begin
                  arvalid <= arvalid;
               end
            end
            RDAT: begin
               if (beat_s) begin
                  data_out    <= rdata;
                  rvalid_tx   <= 1'b1;
                  burst_cnt_r <= burst_cnt_r - 8'd1;
                  remaining_r <= remaining_r - CNT_W'(1);
                  if ((rresp != 2'b00) || (rlast != (burst_cnt_r == 8'd1))) rd_err <= 1'b1;
                  if (last_beat_s) addr_r <= addr_r + step_s;
               end
            end
            FIN:     done <= 1'b1;
            default: begin end
         endcase
      end
   end

`ifdef DRAM_RD_PERF_CNT_EN
   // Cycles where the slave offers data but the transmit side holds us off
   always_ff @(posedge AXI_clk or posedge i_rst) begin
      if (i_rst)
         stall_cnt <= 32'd0;
      else if (accept_s)
         stall_cnt <= 32'd0;
      else if ((state_r == RDAT) && rvalid && !rready && (stall_cnt != 32'hFFFF_FFFF))
         stall_cnt <= stall_cnt + 32'd1;
      else
         stall_cnt <= stall_cnt;
   end
`endif

endmodule

// File: tb/tb_dram_rd_ctrl.sv
// Directed bench for dram_rd_ctrl with a one-burst AXI read slave whose beat data encodes the beat address.
`timescale 1ns/1ps
module tb_dram_rd_ctrl;

   logic         AXI_clk = 1'b0;
   logic         i_rst = 1'b1;
   logic         start = 1'b0;
   logic [31:0]  base_addr = 32'd0;
   logic [23:0]  num_beats = 24'd0;
   logic         tx_almst_full = 1'b0;
   logic [3:0]   arid;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         arvalid;
   logic         arready = 1'b1;
   logic [3:0]   rid = 4'd0;
   logic [255:0] rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic         rvalid;
   logic         rready;
   logic         rvalid_tx;
   logic [255:0] data_out;
   logic         busy;
   logic         done;
   logic         rd_err;
`ifdef DRAM_RD_PERF_CNT_EN
   logic [31:0]  stall_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   dram_rd_ctrl dut (
      .AXI_clk(AXI_clk), .i_rst(i_rst), .start(start), .base_addr(base_addr),
      .num_beats(num_beats), .tx_almst_full(tx_almst_full), .arid(arid), .araddr(araddr),
      .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .rvalid_tx(rvalid_tx), .data_out(data_out), .busy(busy), .done(done),
`ifdef DRAM_RD_PERF_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .rd_err(rd_err)
   );

   always #5 AXI_clk = ~AXI_clk;

   // AXI read slave: one burst at a time, beat data = address repeated, error on err_addr
   logic [31:0] err_addr = 32'hFFFF_FFFF;
   logic        s_busy;
   logic [31:0] s_addr;
   logic [8:0]  s_left;
   always @(posedge AXI_clk or posedge i_rst) begin
      if (i_rst) begin
         s_busy <= 1'b0; s_addr <= 32'd0; s_left <= 9'd0;
         rvalid <= 1'b0; rlast <= 1'b0; rresp <= 2'b00; rdata <= 256'd0;
      end else if (!s_busy) begin
         if (arvalid && arready) begin
            s_busy <= 1'b1;
            s_addr <= araddr;
            s_left <= {1'b0, arlen} + 9'd1;
         end
      end else if (!rvalid || rready) begin
         if (s_left != 9'd0) begin
            rvalid <= 1'b1;
            rdata  <= {8{s_addr}};
            rlast  <= (s_left == 9'd1);
            rresp  <= (s_addr == err_addr) ? 2'b10 : 2'b00;
            s_addr <= s_addr + 32'd32;
            s_left <= s_left - 9'd1;
         end else begin
            rvalid <= 1'b0; rlast <= 1'b0; rresp <= 2'b00; s_busy <= 1'b0;
         end
      end
   end

   // Monitor: log strobed beats, AR handshakes and timing
   logic [255:0] rx [0:255];
   logic [31:0]  ar_addr_log [0:63];
   logic [7:0]   ar_len_log [0:63];
   int strobe_cnt = 0, ar_cnt = 0, cyc = 0, last_strobe_cyc = 0, done_cyc = 0;
   always @(posedge AXI_clk) cyc <= cyc + 1;
   always @(negedge AXI_clk) begin
      if (rvalid_tx) begin
         rx[strobe_cnt[7:0]] <= data_out;
         strobe_cnt          <= strobe_cnt + 1;
         last_strobe_cyc     <= cyc;
      end
      if (arvalid && arready) begin
         ar_addr_log[ar_cnt[5:0]] <= araddr;
         ar_len_log[ar_cnt[5:0]]  <= arlen;
         ar_cnt                   <= ar_cnt + 1;
      end
      if (done) done_cyc <= cyc;
   end

   int s0 = 0, a0 = 0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_xfer(input logic [31:0] b, input logic [23:0] n);
      s0 = strobe_cnt;
      a0 = ar_cnt;
      base_addr = b;
      num_beats = n;
      start = 1'b1;
      @(negedge AXI_clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc);
      int n = 0;
      while (done !== 1'b1 && n < max_cyc) begin
         @(negedge AXI_clk);
         n++;
      end
      check("done_timeout", n < max_cyc, 1);
   endtask

   task automatic wait_strobes(input int k);
      int n = 0;
      while ((strobe_cnt - s0) < k && n < 500) begin
         @(negedge AXI_clk);
         n++;
      end
      check("strobe_timeout", n < 500, 1);
   endtask

   // Expected: beat i carries base+32*i; bursts of 16 at base+512*k, last one partial
   task automatic verify_xfer(input string tag, input logic [31:0] b, input int n);
      int nb;
      check({tag, "_beats"}, strobe_cnt - s0, n);
      for (int i = 0; i < n; i++)
         check({tag, "_data"}, rx[8'(s0 + i)], {8{b + 32'(i) * 32'd32}});
      check({tag, "_ars"}, ar_cnt - a0, (n + 15) / 16);
      for (int k = 0; k * 16 < n; k++) begin
         nb = ((n - k * 16) > 16) ? 16 : (n - k * 16);
         check({tag, "_araddr"}, ar_addr_log[6'(a0 + k)], b + 32'(k) * 32'd512);
         check({tag, "_arlen"}, ar_len_log[6'(a0 + k)], nb - 1);
      end
      check({tag, "_done_lat"}, done_cyc - last_strobe_cyc, 1);
   endtask

   int sc;

   initial begin
      repeat (3) @(negedge AXI_clk);
      check("rst_busy", busy, 0);
      check("rst_arvalid", arvalid, 0);
      check("rst_rready", rready, 0);
      check("rst_strobe", rvalid_tx, 0);
      check("rst_done", done, 0);
      check("rst_err", rd_err, 0);
      i_rst = 1'b0;
      repeat (2) @(negedge AXI_clk);

      // Basic 16-beat transfer with an ignored start mid-transfer
      start_xfer(32'h0000_1000, 24'd16);
      check("t1_busy", busy, 1);
      wait_strobes(5);
      base_addr = 32'h0000_8000; num_beats = 24'd3; start = 1'b1;
      @(negedge AXI_clk);
      start = 1'b0;
      wait_done(200);
      @(negedge AXI_clk);
      check("t1_busy_end", busy, 0);
      check("t1_err", rd_err, 0);
      verify_xfer("t1", 32'h0000_1000, 16);

      // 37 beats: 16+16+5, with AR held until arready rises
      arready = 1'b0;
      start_xfer(32'h0000_1000, 24'd37);
      repeat (2) @(negedge AXI_clk);
      check("t2_arvalid_hold", arvalid, 1);
      check("t2_araddr_hold", araddr, 32'h0000_1000);
      check("t2_arlen_hold", arlen, 8'd15);
      check("t2_arsize", arsize, 3'b101);
      check("t2_arburst", arburst, 2'b01);
      arready = 1'b1;
      wait_done(400);
      @(negedge AXI_clk);
      verify_xfer("t2", 32'h0000_1000, 37);

      // Backpressure for 10 cycles mid-burst
      start_xfer(32'h0000_2000, 24'd16);
      wait_strobes(4);
      check("bp_rready_before", rready, 1);
      tx_almst_full = 1'b1;
      #1 sc = strobe_cnt;
      @(negedge AXI_clk);
      check("bp_rready_low", rready, 0);
      repeat (9) @(negedge AXI_clk);
      #1 check("bp_extra", (strobe_cnt - sc) <= 1, 1);
      tx_almst_full = 1'b0;
      wait_done(200);
      @(negedge AXI_clk);
      verify_xfer("bp", 32'h0000_2000, 16);
`ifdef DRAM_RD_PERF_CNT_EN
      check("bp_stall_cnt", stall_cnt, 32'd10);
`endif

      // Error response on beat 5
      err_addr = 32'h0000_30A0;
      start_xfer(32'h0000_3000, 24'd16);
      wait_done(200);
      check("err_at_done", rd_err, 1);
      @(negedge AXI_clk);
      check("err_sticky", rd_err, 1);
      verify_xfer("err", 32'h0000_3000, 16);
      err_addr = 32'hFFFF_FFFF;

      // Zero length: done 2 cycles after start; start during done is ignored
      start_xfer(32'h0000_5000, 24'd0);
      check("z_err_cleared", rd_err, 0);
      check("z_busy", busy, 1);
      check("z_done_early", done, 0);
      @(negedge AXI_clk);
      check("z_done", done, 1);
      check("z_busy_at_done", busy, 1);
      num_beats = 24'd0; start = 1'b1;
      @(negedge AXI_clk);
      start = 1'b0;
      check("z_busy_drop", busy, 0);
      check("z_done_pulse", done, 0);
      @(negedge AXI_clk);
      check("z_start_ignored", busy, 0);
      check("z_no_ar", ar_cnt - a0, 0);
      check("z_no_beats", strobe_cnt - s0, 0);

      // Reset after 3 beats, then a fresh transfer
      start_xfer(32'h0000_4000, 24'd16);
      wait_strobes(3);
      i_rst = 1'b1;
      #1;
      check("mr_busy", busy, 0);
      check("mr_arvalid", arvalid, 0);
      check("mr_rready", rready, 0);
      check("mr_data", data_out, 256'd0);
      check("mr_araddr", araddr, 32'd0);
      repeat (2) @(negedge AXI_clk);
      i_rst = 1'b0;
      repeat (2) @(negedge AXI_clk);
      start_xfer(32'h0000_1000, 24'd16);
      wait_done(200);
      @(negedge AXI_clk);
      verify_xfer("mr", 32'h0000_1000, 16);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
